// File: rtl/ttm4_sequencer.sv
// ttm4_sequencer: FETCH/EXEC/WB control sequencer for the TTM4 4-bit CPU
module ttm4_sequencer #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       STEP,
  input  logic [7:0] INSTR,
  input  logic       Z_FLAG,
  input  logic       C_FLAG,
  output logic [3:0] PC,
  output logic [3:0] IM,
  output logic [1:0] SEL,
  output logic [1:0] XSEL,
  output logic       nFA_EN,
  output logic       nAND_EN,
  output logic       nOR_EN,
  output logic       nXOR_EN,
  output logic       LD_A,
  output logic       LD_B,
  output logic       LD_OUT,
  output logic       BUSY,
  output logic       HALTED
);
  typedef enum logic [1:0] {FETCH, EXEC, WB, HALT} state_t;
  state_t      state_q, state_d;
  logic [3:0]  pc_q, pc_d, im_q, im_d, en_q, en_d, en_dec, op;
  logic [7:0]  ir_q, ir_d;
  logic [1:0]  sel_q, sel_d, xsel_q, xsel_d, sel_dec, xsel_dec;
  logic [2:0]  ld_q, ld_d, ld_dec;
  logic        taken, fa;
  // decode the incoming instruction in FETCH, the latched one afterwards
  always_comb begin
    op       = state_q == FETCH ? INSTR[7:4] : ir_q[7:4];
    fa       = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7};
    en_dec   = ~{fa, op == 4'h4, op inside {4'h5, 4'h8, 4'h9}, op == 4'h6};
    ld_dec   = {op inside {4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9}, op == 4'h1, op == 4'h8};
    sel_dec  = op == 4'h3 ? 2'b11 : op == 4'h7 ? 2'b10 : op inside {4'h2, 4'h4, 4'h5, 4'h6} ? 2'b01 : 2'b00;
    xsel_dec = op == 4'h1 ? 2'b01 : op == 4'h9 ? 2'b10 : 2'b00;
    taken    = op == 4'hA || (op == 4'hB && !C_FLAG) || (op == 4'hC && Z_FLAG);
  end
  // next-state: controls latch on FETCH exit, strobes pulse in WB, PC moves on WB exit
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    im_d    = im_q;
    sel_d   = sel_q;
    xsel_d  = xsel_q;
    en_d    = en_q;
    ld_d    = 3'b000;
    case (state_q)
      FETCH: if (RUN || STEP) begin
        state_d = EXEC;
        ir_d    = INSTR;
        im_d    = op == 4'h8 ? 4'h0 : INSTR[3:0];
        sel_d   = sel_dec;
        xsel_d  = xsel_dec;
        en_d    = en_dec;
      end
      EXEC: begin
        state_d = WB;
        ld_d    = ld_dec;
      end
      WB: begin
        state_d = op == 4'hD ? HALT : FETCH;
        pc_d    = op == 4'hD ? pc_q : taken ? ir_q[3:0] : pc_q + 4'd1;
        im_d    = 4'h0;
        sel_d   = 2'b00;
        xsel_d  = 2'b00;
        en_d    = 4'hF;
      end
      default: state_d = HALT;
    endcase
  end
  // all sequencer state and registered outputs; reset wins over everything
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      im_q    <= 4'h0;
      sel_q   <= 2'b00;
      xsel_q  <= 2'b00;
      en_q    <= 4'hF;
      ld_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      im_q    <= im_d;
      sel_q   <= sel_d;
      xsel_q  <= xsel_d;
      en_q    <= en_d;
      ld_q    <= ld_d;
    end
  end
  assign PC                                 = pc_q;
  assign IM                                 = im_q;
  assign SEL                                = sel_q;
  assign XSEL                               = xsel_q;
  assign {nFA_EN, nAND_EN, nOR_EN, nXOR_EN} = en_q;
  assign {LD_A, LD_B, LD_OUT}               = ld_q;
  assign BUSY                               = state_q == EXEC || state_q == WB;
  assign HALTED                             = state_q == HALT;
endmodule

// File: tb/tb_ttm4_sequencer.sv
// tb_ttm4_sequencer: table-driven cycle vectors plus halt/reset corner sequences
module tb_ttm4_sequencer;
  logic       CLK = 0, RST = 1, RUN = 0, STEP = 0, Z_FLAG = 0, C_FLAG = 0;
  logic [7:0] INSTR;
  logic [3:0] PC, IM;
  logic [1:0] SEL, XSEL;
  logic       nFA_EN, nAND_EN, nOR_EN, nXOR_EN, LD_A, LD_B, LD_OUT, BUSY, HALTED;
  logic [7:0] rom [16];
  int         tests = 0, fails = 0;

  ttm4_sequencer #(.RESET_PC(4'h0)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .INSTR(INSTR),
    .Z_FLAG(Z_FLAG), .C_FLAG(C_FLAG), .PC(PC), .IM(IM), .SEL(SEL), .XSEL(XSEL),
    .nFA_EN(nFA_EN), .nAND_EN(nAND_EN), .nOR_EN(nOR_EN), .nXOR_EN(nXOR_EN),
    .LD_A(LD_A), .LD_B(LD_B), .LD_OUT(LD_OUT), .BUSY(BUSY), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;
  assign INSTR = rom[PC];

  // observed vector: pc, im, sel, xsel, {nFA,nAND,nOR,nXOR}, {LD_A,LD_B,LD_OUT}, busy, halted
  typedef struct {
    logic        run, step, c, z;
    logic [20:0] exp;
  } vec_t;
  vec_t vt[$];

  function automatic logic [20:0] pk(logic [3:0] pc, im, logic [1:0] sel, xsel,
                                     logic [3:0] en, logic [2:0] ld, logic busy, halted);
    return {pc, im, sel, xsel, en, ld, busy, halted};
  endfunction

  function automatic logic [20:0] obs();
    return {PC, IM, SEL, XSEL, nFA_EN, nAND_EN, nOR_EN, nXOR_EN, LD_A, LD_B, LD_OUT, BUSY, HALTED};
  endfunction

  task automatic chk(string name, logic [20:0] exp);
    tests++;
    if (obs() !== exp) begin
      fails++;
      $display("FAIL %s: got pc=%h im=%h sel=%b xsel=%b en=%b ld=%b busy=%b halted=%b, expected %h/%h/%b/%b/%b/%b/%b/%b",
               name, PC, IM, SEL, XSEL, {nFA_EN, nAND_EN, nOR_EN, nXOR_EN}, {LD_A, LD_B, LD_OUT}, BUSY, HALTED,
               exp[20:17], exp[16:13], exp[12:11], exp[10:9], exp[8:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // one free-run instruction: EXEC, WB (with strobe), back to FETCH at next_pc
  task automatic add_instr(logic c, z, logic [3:0] pc, im, logic [1:0] sel, xsel,
                           logic [3:0] en, logic [2:0] ld, logic [3:0] next_pc);
    vt.push_back('{1'b1, 1'b0, c, z, pk(pc, im, sel, xsel, en, 3'b000, 1'b1, 1'b0)});
    vt.push_back('{1'b1, 1'b0, c, z, pk(pc, im, sel, xsel, en, ld, 1'b1, 1'b0)});
    vt.push_back('{1'b1, 1'b0, c, z, pk(next_pc, 4'h0, 2'b00, 2'b00, 4'hF, 3'b000, 1'b0, 1'b0)});
  endtask

  task automatic add_one(logic run, step, logic [20:0] exp);
    vt.push_back('{run, step, 1'b0, 1'b0, exp});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  localparam logic [20:0] IDLE0 = 21'({4'h0, 4'h0, 2'b00, 2'b00, 4'hF, 3'b000, 1'b0, 1'b0});
  localparam logic [20:0] IDLE1 = 21'({4'h1, 4'h0, 2'b00, 2'b00, 4'hF, 3'b000, 1'b0, 1'b0});

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'hE0;
    rom[0] = 8'h93; rom[1] = 8'h05; rom[2] = 8'h30; rom[3] = 8'hB7;
    rom[7] = 8'hC9; rom[9] = 8'hB4; rom[10] = 8'h8F; rom[11] = 8'h12;
    rom[12] = 8'hAF; rom[15] = 8'h41;

    add_instr(0, 0, 4'h0, 4'h3, 2'b00, 2'b10, 4'b1101, 3'b100, 4'h1);
    add_instr(0, 0, 4'h1, 4'h5, 2'b00, 2'b00, 4'b0111, 3'b100, 4'h2);
    add_instr(0, 0, 4'h2, 4'h0, 2'b11, 2'b00, 4'b0111, 3'b100, 4'h3);
    add_instr(0, 0, 4'h3, 4'h7, 2'b00, 2'b00, 4'b1111, 3'b000, 4'h7);
    add_instr(0, 1, 4'h7, 4'h9, 2'b00, 2'b00, 4'b1111, 3'b000, 4'h9);
    add_instr(1, 0, 4'h9, 4'h4, 2'b00, 2'b00, 4'b1111, 3'b000, 4'hA);
    add_instr(0, 0, 4'hA, 4'h0, 2'b00, 2'b00, 4'b1101, 3'b001, 4'hB);
    add_instr(0, 0, 4'hB, 4'h2, 2'b00, 2'b01, 4'b0111, 3'b010, 4'hC);
    add_instr(0, 0, 4'hC, 4'hF, 2'b00, 2'b00, 4'b1111, 3'b000, 4'hF);
    add_instr(0, 0, 4'hF, 4'h1, 2'b01, 2'b00, 4'b1011, 3'b100, 4'h0);
    add_one(0, 0, IDLE0);
    add_one(0, 0, IDLE0);
    add_one(0, 1, pk(4'h0, 4'h3, 2'b00, 2'b10, 4'b1101, 3'b000, 1'b1, 1'b0));
    add_one(0, 1, pk(4'h0, 4'h3, 2'b00, 2'b10, 4'b1101, 3'b100, 1'b1, 1'b0));
    add_one(0, 0, IDLE1);
    add_one(0, 0, IDLE1);

    tick();
    chk("reset", IDLE0);
    RST = 0;
    foreach (vt[i]) begin
      RUN = vt[i].run; STEP = vt[i].step; C_FLAG = vt[i].c; Z_FLAG = vt[i].z;
      tick();
      chk($sformatf("vec%0d", i), vt[i].exp);
    end

    RUN = 0; STEP = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle%0d", i), IDLE1);
    end

    rom[2] = 8'hD0;
    RST = 1; tick(); RST = 0;
    RUN = 1;
    for (int i = 0; i < 9; i++) tick();
    chk("halt_enter", pk(4'h2, 4'h0, 2'b00, 2'b00, 4'hF, 3'b000, 1'b0, 1'b1));
    for (int i = 0; i < 5; i++) begin
      STEP = i[0];
      tick();
      chk($sformatf("halt_hold%0d", i), pk(4'h2, 4'h0, 2'b00, 2'b00, 4'hF, 3'b000, 1'b0, 1'b1));
    end
    STEP = 0;
    RST = 1; tick(); RST = 0; RUN = 0;
    chk("halt_reset", IDLE0);

    RUN = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("wb_ld_a", pk(4'h1, 4'h5, 2'b00, 2'b00, 4'b0111, 3'b100, 1'b1, 1'b0));
    RST = 1; tick(); RST = 0; RUN = 0;
    chk("wb_reset", IDLE0);
    tick();
    chk("wb_reset_hold", IDLE0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ttm4_sequencer.md
Name: ttm4_sequencer

Overview:
- Control sequencer for the TTM4 4-bit CPU emulator.
- Fetches 8-bit instructions from a combinational program ROM and drives the ALU control inputs: IM, SEL, the four active-low unit enables, and the X-source select.
- Issues one-cycle register load strobes, and takes conditional jumps on the ALU's latched Z/C flags.
- Supports free-run and single-step operation, plus a HALT instruction.

Parameters:
- RESET_PC, 4'h0, PC value loaded on reset.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous active-high reset, sampled on the rising edge of CLK.
- RUN  input  1  level; 1 = free-run, 0 = single-step mode.
- STEP  input  1  one-cycle pulse; starts one instruction when RUN=0.
- INSTR  input  8  ROM data at address PC; [7:4] opcode, [3:0] immediate.
- Z_FLAG  input  1  ALU zero flag (latched inside ALU).
- C_FLAG  input  1  ALU carry flag (latched inside ALU).
- PC  output  4  ROM address.
- IM  output  4  immediate to ALU.
- SEL  output  2  ALU SEL: [0] 0=IM, 1=Y(B); [1] invert Y and carry-in (subtract).
- XSEL  output  2  ALU X source: 00=A, 01=B, 10=zero, 11=reserved (drive zero).
- nFA_EN  output  1  adder enable, active-low; also flag-load enable.
- nAND_EN  output  1  AND enable, active-low.
- nOR_EN  output  1  OR enable, active-low.
- nXOR_EN  output  1  XOR enable, active-low.
- LD_A  output  1  load register A from STOREDATA at end of cycle.
- LD_B  output  1  load register B from STOREDATA at end of cycle.
- LD_OUT  output  1  load output port from STOREDATA at end of cycle.
- BUSY  output  1  high in EXEC and WB.
- HALTED  output  1  high in HALT state.

Behaviour:
- States and transitions:
  - FETCH: goes to EXEC when RUN=1 or STEP=1; otherwise stays in FETCH.
  - EXEC: always goes to WB.
  - WB: goes to FETCH. If the opcode is 0xD, it goes to HALT instead.
  - HALT: stays in HALT until RST; RUN and STEP are ignored.
- Latency: one instruction takes exactly 3 cycles in free-run (FETCH, EXEC, WB).
- FETCH→EXEC edge:
  - IR <= INSTR.
  - All control outputs (IM, SEL, XSEL, n*_EN) are registered from the decode of INSTR.
  - They hold through EXEC and WB and return to idle on the WB exit edge.
- Idle values: IM=0, SEL=00, XSEL=00, all n*_EN=1.
- At most one n*_EN is low at any time.
- LD_A / LD_B / LD_OUT: high only during WB, at most one at a time, for exactly one cycle.
- Opcode map:
  - 0: A=A+IM (XSEL00, SEL00, FA, LD_A)
  - 1: B=B+IM (XSEL01, SEL00, FA, LD_B)
  - 2: A=A+B (SEL01, FA, LD_A)
  - 3: A=A-B (SEL11, FA, LD_A)
  - 4: A=A&B (SEL01, AND, LD_A)
  - 5: A=A|B (SEL01, OR, LD_A)
  - 6: A=A^B (SEL01, XOR, LD_A)
  - 7: A=A-IM (SEL10, FA, LD_A)
  - 8: OUT=A (XSEL00, SEL00, IM forced 0, OR, LD_OUT)
  - 9: A=IM (XSEL10, SEL00, OR, LD_A)
  - A: JMP IM
  - B: JNC IM, taken when C_FLAG=0
  - C: JZ IM, taken when Z_FLAG=1
  - D: HALT
  - E, F: NOP
  - Opcodes A–F: all enables high, no load strobe.
- Flags are modified only by FA opcodes (0,1,2,3,7); the ALU reloads them each cycle nFA_EN is low.
- Jump conditions are sampled during WB.
- PC update on the WB exit edge:
  - taken jump: PC <= IM.
  - otherwise: PC <= PC+1, mod 16 (15 wraps to 0).
- HALT: PC holds its value (not incremented).
- STEP:
  - Pulses while BUSY or HALTED are ignored and not queued.
  - With RUN=0, exactly one instruction executes per accepted pulse.
- RUN dropping mid-instruction: the current instruction completes; the sequencer then waits in FETCH.
- Reset values: PC=RESET_PC, state=FETCH, IR=0, outputs at idle values, all load strobes 0, BUSY=0, HALTED=0.
- RST in any state, including mid-EXEC/WB, takes effect on that edge: strobes drop and no register or PC update occurs.
- RST has priority over RUN and STEP in the same cycle.

Test Plan:
- Reset, RUN=1, ROM[0]=0x93, ROM[1]=0x05 → cycle 2: XSEL=10, SEL=00, nOR_EN=0, IM=3; cycle 3: LD_A=1. After 3 cycles PC=1. Next instruction drives nFA_EN=0, SEL=00, IM=5 and LD_A in its WB.
- SUB: ROM[k]=0x30 → SEL=11, nFA_EN=0 in EXEC and WB; all other enables high; LD_A only in WB.
- Jumps: JNC 0x7 with C_FLAG=0 → PC=7. With C_FLAG=1 → PC=k+1. JZ with Z_FLAG=1 → PC=IM. At PC=15 a non-jump → PC=0.
- Step mode: RUN=0 → sequencer stays in FETCH, PC unchanged for 10 cycles. One STEP pulse → exactly one 3-cycle instruction. STEP during BUSY → ignored.
- HALT: ROM[2]=0xD0 → HALTED=1 after its WB, PC stays 2. RUN and STEP have no effect. RST → PC=0, HALTED=0.
- RST asserted during WB of opcode 0 → LD_A=0 on that cycle, PC=RESET_PC, all enables high next cycle.
